// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - byte-serial load/store unit (B/H/W, signed/unsigned) to an 8-bit data memory
// Optional build macro: LSU_MISALIGN_TRAP_EN (misaligned halfword/word accesses take the error path).
module load_store_unit #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [2:0]            funct3,
    input  logic [31:0]           endereco,
    input  logic [31:0]           write_data,
    output logic [ADDR_WIDTH-1:0] mem_endereco,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [7:0]            mem_wdata,
    input  logic [7:0]            mem_rdata,
    output logic                  resp_valid,
    output logic [31:0]           read_data,
    output logic                  resp_erro
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t      state;
    logic [1:0]  idx;
    logic [1:0]  last_q;
    logic        write_q;
    logic [2:0]  funct3_q;
    logic [31:0] wdata_q;
    logic [31:0] rbuf;

    logic [1:0]  req_last;
    logic        legal_f3;
    logic [32:0] end_addr;
    logic        out_of_range;
    logic        misaligned;
    logic        accept_ok;
    logic [1:0]  next_idx;
    logic [31:0] next_buf;
    logic [31:0] load_ext;

    always_comb begin
        case (funct3[1:0])
            2'b01:   req_last = 2'd1;
            2'b10:   req_last = 2'd3;
            default: req_last = 2'd0;
        endcase

        if (req_write)
            legal_f3 = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
        else
            legal_f3 = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                       (funct3 == 3'b100) || (funct3 == 3'b101);

        // 33-bit sum so a 32-bit wrap also lands outside the memory window
        end_addr     = {1'b0, endereco} + {31'b0, req_last};
        out_of_range = (end_addr >> ADDR_WIDTH) != 33'd0;

`ifdef LSU_MISALIGN_TRAP_EN
        misaligned = ((funct3[1:0] == 2'b01) && endereco[0]) ||
                     ((funct3[1:0] == 2'b10) && (endereco[1:0] != 2'b00));
`else
        misaligned = 1'b0;
`endif

        accept_ok = legal_f3 && !out_of_range && !misaligned;
        next_idx  = idx + 2'd1;

        next_buf = rbuf;
        next_buf[{idx, 3'b000} +: 8] = mem_rdata;

        case (funct3_q)
            3'b000:  load_ext = {{24{next_buf[7]}}, next_buf[7:0]};
            3'b001:  load_ext = {{16{next_buf[15]}}, next_buf[15:0]};
            3'b100:  load_ext = {24'h000000, next_buf[7:0]};
            3'b101:  load_ext = {16'h0000, next_buf[15:0]};
            default: load_ext = next_buf;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            idx          <= 2'd0;
            last_q       <= 2'd0;
            write_q      <= 1'b0;
            funct3_q     <= 3'b000;
            wdata_q      <= 32'h0;
            rbuf         <= 32'h0;
            read_data    <= 32'h0;
            resp_valid   <= 1'b0;
            resp_erro    <= 1'b0;
            req_ready    <= 1'b1;
            mem_endereco <= '0;
            mem_read     <= 1'b0;
            mem_write    <= 1'b0;
            mem_wdata    <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        if (accept_ok) begin
                            state        <= ACCESS;
                            idx          <= 2'd0;
                            last_q       <= req_last;
                            write_q      <= req_write;
                            funct3_q     <= funct3;
                            wdata_q      <= write_data;
                            mem_endereco <= endereco[ADDR_WIDTH-1:0];
                            mem_read     <= !req_write;
                            mem_write    <= req_write;
                            mem_wdata    <= req_write ? write_data[7:0] : 8'h00;
                        end else begin
                            state      <= DONE;
                            resp_valid <= 1'b1;
                            resp_erro  <= 1'b1;
                        end
                    end
                end
                ACCESS: begin
                    if (!write_q)
                        rbuf <= next_buf;
                    if (idx == last_q) begin
                        state        <= DONE;
                        resp_valid   <= 1'b1;
                        resp_erro    <= 1'b0;
                        mem_endereco <= '0;
                        mem_read     <= 1'b0;
                        mem_write    <= 1'b0;
                        mem_wdata    <= 8'h00;
                        if (!write_q)
                            read_data <= load_ext;
                    end else begin
                        idx          <= next_idx;
                        mem_endereco <= mem_endereco + ADDR_WIDTH'(1);
                        mem_wdata    <= write_q ? wdata_q[{next_idx, 3'b000} +: 8] : 8'h00;
                    end
                end
                DONE: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    resp_erro  <= 1'b0;
                    req_ready  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter ADDR_WIDTH, default 10, byte-address width of the data memory (1024 bytes).
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req_valid  input  1  request present from execute stage.
REQ-005 req_ready  output  1  unit can accept a request (high only in IDLE).
REQ-006 req_write  input  1  1 = store, 0 = load.
REQ-007 funct3  input  3  access type: 000 B, 001 H, 010 W, 100 BU, 101 HU (loads); 000/001/010 (stores).
REQ-008 endereco  input  32  byte address of access.
REQ-009 write_data  input  32  store data, little-endian.
REQ-010 mem_endereco  output  ADDR_WIDTH  byte address to data memory.
REQ-011 mem_read / mem_write  output  1 each  byte strobes to data memory.
REQ-012 mem_wdata  output  8  byte to store.
REQ-013 mem_rdata  input  8  byte read, combinational from mem_endereco.
REQ-014 resp_valid  output  1  one-cycle completion pulse.
REQ-015 read_data  output  32  extended load result, held until next resp_valid.
REQ-016 resp_erro  output  1  request rejected; valid with resp_valid.

Function
REQ-017 FSM states IDLE, ACCESS, DONE; IDLE->ACCESS on req_valid&&req_ready with legal request; ACCESS->DONE after last byte; DONE->IDLE unconditionally.
REQ-018 Request fields latched on acceptance; input changes afterwards have no effect.
REQ-019 Byte count N: 1 for 000/100, 2 for 001/101, 4 for 010.
REQ-020 ACCESS issues one byte per cycle, offsets 0..N-1, at address endereco+k, with exactly one of mem_read/mem_write high.
REQ-021 Loads capture mem_rdata at end of each ACCESS cycle into byte lane k.
REQ-022 Stores drive mem_wdata = write_data[8k+7:8k] in cycle k.
REQ-023 Latency: accepted at cycle T, bytes at T+1..T+N, resp_valid at T+N+1, req_ready high again at T+N+2.
REQ-024 Load extension: 000 sign-extend bit 7, 001 sign-extend bit 15, 100/101 zero-extend, 010 none.
REQ-025 Stores do not modify read_data.
REQ-026 Illegal funct3 (011, 110, 111; any of 100/101 with store) -> IDLE->DONE directly, no memory strobe, resp_erro=1.
REQ-027 Out-of-range (endereco+N-1 >= 2^ADDR_WIDTH, including 32-bit wrap) -> same error path as REQ-026; no partial access.
REQ-028 mem_read, mem_write, mem_wdata low outside ACCESS; mem_endereco don't-care then but driven 0.
REQ-029 req_valid in ACCESS/DONE ignored (req_ready=0); requester holds it.

Reset
REQ-030 reset forces IDLE at next edge, overriding all other events including an acceptance the same cycle.
REQ-031 After reset: req_ready=1, resp_valid=0, resp_erro=0, read_data=0, all mem outputs 0.
REQ-032 reset during ACCESS aborts: no further strobes, no resp_valid; bytes already stored stay.

Configuration
REQ-033 Macro LSU_MISALIGN_TRAP_EN: defined -> halfword with endereco[0]!=0 or word with endereco[1:0]!=0 takes error path (REQ-026), no strobe.
REQ-034 Undefined -> misaligned accesses complete normally via byte sequencing, same latency as aligned.

Verification
REQ-035 SW endereco=0x10, write_data=0xA1B2C3D4 -> bytes D4,C3,B2,A1 at 0x10..0x13 over 4 cycles, resp_valid at T+5, resp_erro=0.
REQ-036 After REQ-035, LB 0x13 -> read_data=0xFFFFFFA1; LBU 0x13 -> 0x000000A1; LH 0x12 -> 0xFFFFA1B2; LW 0x10 -> 0xA1B2C3D4.
REQ-037 LW endereco=0x3FE -> resp_erro=1 at T+1, no mem strobe, read_data unchanged.
REQ-038 LH endereco=0x11: macro defined -> resp_erro=1, no strobe; undefined -> read_data=0xFFFFB2C3 at T+3.
REQ-039 Assert reset during cycle 2 of an SW to 0x20 -> only bytes 0x20,0x21 written, no resp_valid, req_ready=1 next cycle.
REQ-040 req_valid held high with funct3=111 -> resp_erro pulses every 2 cycles, never any mem strobe.
